// File: rtl/debounce_scan_if.sv
// -----------------------------------------------------------------------------
// debounce_scan_if
// Bundles the scan-enable, raw switch inputs and the debounced outputs of
// debounce_scan into one port.
//   en        : scan enable (master -> slave)
//   sw        : raw asynchronous switch inputs, N bits (master -> slave)
//   sw_dbnc   : debounced levels, N bits (slave -> master)
//   sw_hi     : one-cycle rising-event pulses, N bits (slave -> master)
//   sw_lo     : one-cycle falling-event pulses, N bits (slave -> master)
//   scan_idx  : channel handled on the current scan tick (slave -> master)
// -----------------------------------------------------------------------------
interface debounce_scan_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          en;
    logic [N-1:0]  sw;
    logic [N-1:0]  sw_dbnc;
    logic [N-1:0]  sw_hi;
    logic [N-1:0]  sw_lo;
    logic [IW-1:0] scan_idx;

    modport master (
        output en,
        output sw,
        input  sw_dbnc,
        input  sw_hi,
        input  sw_lo,
        input  scan_idx
    );

    modport slave (
        input  en,
        input  sw,
        output sw_dbnc,
        output sw_hi,
        output sw_lo,
        output scan_idx
    );
endinterface

// File: rtl/debounce_scan.sv
// -----------------------------------------------------------------------------
// debounce_scan
// Time-multiplexed debouncer: one shared compare/count engine visits one switch
// channel per scan tick in round-robin order. Each channel keeps a WIDTH-bit
// mismatch counter and a debounced level; a change is accepted after
// THRESH = 2**WIDTH-1 consecutive mismatching visits, and is announced with a
// one-cycle sw_hi / sw_lo pulse aligned with the new sw_dbnc value.
//   clk50m : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : debounce_scan_if slave (en, sw in; sw_dbnc, sw_hi, sw_lo,
//            scan_idx out)
// -----------------------------------------------------------------------------
module debounce_scan #(
    parameter int N        = 4,
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic           clk50m,
    input  logic           rst_n,
    debounce_scan_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Counter value on which the next mismatching visit accepts the change.
    localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'((2 ** WIDTH) - 2);
    localparam logic [PW-1:0]    PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]    IDX_LAST  = IW'(N - 1);

    logic [N-1:0]     sync1_q;
    logic [N-1:0]     sync2_q;
    logic [PW-1:0]    pcnt_q,  pcnt_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [WIDTH-1:0] cnt_q [N];
    logic [WIDTH-1:0] cnt_d [N];
    logic [N-1:0]     dbnc_q,  dbnc_d;
    logic [N-1:0]     hi_q,    hi_d;
    logic [N-1:0]     lo_q,    lo_d;
    logic             tick_s;

    assign tick_s = (pcnt_q == PCNT_LAST);

    // Next-state for prescaler, scan pointer and the visited channel.
    always_comb begin
        pcnt_d = pcnt_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        dbnc_d = dbnc_q;
        hi_d   = '0;
        lo_d   = '0;
        if (bus.en) begin
            if (tick_s) begin
                pcnt_d = '0;
                if (sync2_q[idx_q] == dbnc_q[idx_q]) begin
                    // Any matching visit discards accumulated evidence.
                    cnt_d[idx_q] = '0;
                end else if (cnt_q[idx_q] != CNT_LAST) begin
                    cnt_d[idx_q] = cnt_q[idx_q] + WIDTH'(1);
                end else begin
                    cnt_d[idx_q]  = '0;
                    dbnc_d[idx_q] = sync2_q[idx_q];
                    if (sync2_q[idx_q]) begin
                        hi_d[idx_q] = 1'b1;
                    end else begin
                        lo_d[idx_q] = 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end else begin
            // Frozen: everything holds and the event pulses stay low.
            pcnt_d = pcnt_q;
        end
    end

    // State registers; the synchronizer runs regardless of en.
    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pcnt_q  <= '0;
            idx_q   <= '0;
            dbnc_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.sw;
            sync2_q <= sync1_q;
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            dbnc_q  <= dbnc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sw_dbnc  = dbnc_q;
    assign bus.sw_hi    = hi_q;
    assign bus.sw_lo    = lo_q;
    assign bus.scan_idx = idx_q;
endmodule

// File: tb/tb_debounce_scan.sv
// -----------------------------------------------------------------------------
// tb_debounce_scan
// Self-checking bench for debounce_scan (N=4, WIDTH=4, PRESCALE=1). Every
// stimulus edge pushes the pulse it should cause (channel, direction, latency
// window) onto a scoreboard queue; a monitor pops the matching entry when the
// DUT pulses and flags unexpected, late or overlapping pulses.
// -----------------------------------------------------------------------------
module tb_debounce_scan;
    localparam int N        = 4;
    localparam int WIDTH    = 4;
    localparam int PRESCALE = 1;
    localparam int THRESH   = (1 << WIDTH) - 1;
    localparam int LAT_LO   = 2 + N * (THRESH - 1) * PRESCALE + 1;
    localparam int LAT_HI   = 2 + N * THRESH * PRESCALE;

    typedef struct {
        int ch;
        bit rise;
        int t0;
        int lo;
        int hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    exp_t sbq[$];
    int   last_hi [N];
    int   last_lo [N];

    logic [N-1:0] mon_p;
    bit           mon_rise;
    int           mon_found;
    int           mon_lat;

    debounce_scan_if #(.N(N)) ifc ();

    debounce_scan #(.N(N), .WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk50m (clk),
        .rst_n  (rst_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int ch, input bit rise, input int t0, input int extra);
        sbq.push_back(exp_t'{ch, rise, t0, LAT_LO + extra, LAT_HI + extra});
    endtask

    // Scoreboard monitor: match pulses against expectations, catch timeouts.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_p = ifc.sw_hi | ifc.sw_lo;
            if (mon_p != '0) begin
                check_val("one_pulse_per_cycle", $countones(mon_p), 1);
            end
            for (int i = 0; i < N; i++) begin
                if (mon_p[i]) begin
                    mon_rise  = ifc.sw_hi[i];
                    mon_found = -1;
                    for (int j = 0; j < sbq.size(); j++) begin
                        if (mon_found < 0 && sbq[j].ch == i && sbq[j].rise == mon_rise) mon_found = j;
                    end
                    if (mon_found >= 0) begin
                        mon_lat = cyc - sbq[mon_found].t0;
                        check_val($sformatf("latency_ch%0d_was_%0d", i, mon_lat),
                                  (mon_lat >= sbq[mon_found].lo && mon_lat <= sbq[mon_found].hi), 1);
                        check_val($sformatf("level_with_pulse_ch%0d", i), ifc.sw_dbnc[i], mon_rise);
                        if (mon_rise) last_hi[i] = cyc;
                        else          last_lo[i] = cyc;
                        sbq.delete(mon_found);
                    end else begin
                        check_val($sformatf("unexpected_pulse_ch%0d", i), mon_p[i], 1'b0);
                    end
                end
            end
            for (int j = sbq.size() - 1; j >= 0; j--) begin
                if (cyc - sbq[j].t0 > sbq[j].hi) begin
                    check_val($sformatf("missing_pulse_ch%0d", sbq[j].ch), cyc - sbq[j].t0, sbq[j].hi);
                    sbq.delete(j);
                end
            end
        end
    end

    bit bval [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int blen [5] = '{5, 1, 3, 5, 2};
    int mx, mn;
    logic [1:0]   idx_f;
    logic [N-1:0] dbnc_f;

    initial begin
        rst_n  = 1'b0;
        ifc.en = 1'b1;
        ifc.sw = 4'hF;
        for (int i = 0; i < N; i++) begin
            last_hi[i] = 0;
            last_lo[i] = 0;
        end

        // 1. Startup with every switch held high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_dbnc", ifc.sw_dbnc, 4'h0);
            check_val("rst_hi", ifc.sw_hi, 4'h0);
            check_val("rst_lo", ifc.sw_lo, 4'h0);
            check_val("rst_idx", ifc.scan_idx, 2'd0);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < N; i++) expect_pulse(i, 1'b1, cyc, 0);
        repeat (70) step();
        check_val("s1_queue", sbq.size(), 0);
        check_val("s1_dbnc", ifc.sw_dbnc, 4'hF);
        mx = last_hi[0];
        mn = last_hi[0];
        for (int i = 1; i < N; i++) begin
            if (last_hi[i] > mx) mx = last_hi[i];
            if (last_hi[i] < mn) mn = last_hi[i];
        end
        check_val("s1_consecutive", mx - mn, N - 1);
        ifc.sw = 4'h0;
        for (int i = 0; i < N; i++) expect_pulse(i, 1'b0, cyc, 0);
        repeat (70) step();
        check_val("s1_release_queue", sbq.size(), 0);
        check_val("s1_release_dbnc", ifc.sw_dbnc, 4'h0);

        // 2. Bounce on ch1 must never be accepted.
        for (int k = 0; k < 5; k++) begin
            ifc.sw[1] = bval[k];
            repeat (blen[k]) step();
        end
        ifc.sw[1] = 1'b0;
        repeat (80) step();
        check_val("s2_dbnc", ifc.sw_dbnc, 4'h0);

        // 3. Clean press and release on ch2.
        ifc.sw[2] = 1'b1;
        expect_pulse(2, 1'b1, cyc, 0);
        repeat (100) step();
        check_val("s3_dbnc_high", ifc.sw_dbnc, 4'b0100);
        ifc.sw[2] = 1'b0;
        expect_pulse(2, 1'b0, cyc, 0);
        repeat (100) step();
        check_val("s3_queue", sbq.size(), 0);
        check_val("s3_dbnc_low", ifc.sw_dbnc, 4'h0);

        // 4. Simultaneous rise on ch0 and ch3, timed so ch0 is visited first.
        for (int g = 0; g < N && ifc.scan_idx != 2'd2; g++) step();
        check_val("s4_align", ifc.scan_idx, 2'd2);
        ifc.sw = 4'b1001;
        expect_pulse(0, 1'b1, cyc, 0);
        expect_pulse(3, 1'b1, cyc, 0);
        repeat (80) step();
        check_val("s4_queue", sbq.size(), 0);
        check_val("s4_gap", last_hi[3] - last_hi[0], 3);
        ifc.sw = 4'h0;
        expect_pulse(0, 1'b0, cyc, 0);
        expect_pulse(3, 1'b0, cyc, 0);
        repeat (80) step();
        check_val("s4_release_queue", sbq.size(), 0);

        // 5. Enable freeze in the middle of a debounce on ch0.
        ifc.sw[0] = 1'b1;
        expect_pulse(0, 1'b1, cyc, 20);
        repeat (30) step();
        idx_f  = ifc.scan_idx;
        dbnc_f = ifc.sw_dbnc;
        ifc.en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("frz_idx", ifc.scan_idx, idx_f);
            check_val("frz_dbnc", ifc.sw_dbnc, dbnc_f);
            check_val("frz_pulse", ifc.sw_hi | ifc.sw_lo, 4'h0);
        end
        @(posedge clk);
        #1;
        ifc.en = 1'b1;
        repeat (80) step();
        check_val("s5_queue", sbq.size(), 0);
        check_val("s5_dbnc", ifc.sw_dbnc, 4'b0001);
        ifc.sw[0] = 1'b0;
        expect_pulse(0, 1'b0, cyc, 0);
        repeat (80) step();
        check_val("s5_release_queue", sbq.size(), 0);

        // 6. Reset in the middle of a debounce on ch1.
        ifc.sw[1] = 1'b1;
        expect_pulse(1, 1'b1, cyc, 0);
        repeat (40) step();
        rst_n = 1'b0;
        sbq.delete();
        step();
        rst_n = 1'b1;
        check_val("s6_dbnc", ifc.sw_dbnc, 4'h0);
        check_val("s6_idx", ifc.scan_idx, 2'd0);
        check_val("s6_pulse", ifc.sw_hi | ifc.sw_lo, 4'h0);
        expect_pulse(1, 1'b1, cyc, 0);
        repeat (80) step();
        check_val("s6_queue", sbq.size(), 0);
        check_val("s6_dbnc_high", ifc.sw_dbnc, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
